pong_anim_graph: RTL and testbench

- Animated pixel generator for the Pong game.
- Consumes pixel coordinates and video_on from the VGA sync stage and produces the 4-bit colour code that the top level registers onto rgb.
- Holds the paddle position, ball position and velocity, plus a serve/play/miss state machine.
- All state updates once per frame, on a refresh tick derived from the pixel scan.

---
 rtl/pong_pkg.sv | 28 ++
 rtl/pong_anim_graph_if.sv | 30 +++
 rtl/pong_object_mux.sv | 48 ++++
 rtl/pong_anim_graph.sv | 163 ++++++++++++++++
 tb/tb_pong_anim_graph.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/pong_pkg.sv
// Shared definitions for the Pong animated graphics block.
// Contents:
//   - ST_SERVE / ST_PLAY / ST_MISS : FSM state encodings
//   - H_ACTIVE, V_ACTIVE            : visible screen size
//   - TICK_LINE                     : line on which the once-per-frame refresh fires
//   - CLR_*                         : 4-bit colour codes
//   - in_range()                    : inclusive range test on 10-bit coordinates
package pong_pkg;

  localparam logic [1:0] ST_SERVE = 2'd0;
  localparam logic [1:0] ST_PLAY  = 2'd1;
  localparam logic [1:0] ST_MISS  = 2'd2;

  localparam int unsigned H_ACTIVE  = 640;
  localparam int unsigned V_ACTIVE  = 480;
  localparam int unsigned TICK_LINE = 481;

  localparam logic [3:0] CLR_BLACK  = 4'h0;
  localparam logic [3:0] CLR_PADDLE = 4'hA;
  localparam logic [3:0] CLR_WALL   = 4'hC;
  localparam logic [3:0] CLR_BALL   = 4'hF;

  function automatic logic in_range(input logic [9:0] v, input logic [9:0] lo,
                                    input logic [9:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/pong_anim_graph_if.sv
// Pixel-scan / control bundle between the VGA sync stage, the buttons and the
// Pong graphics generator.
//   tick_25m  : pixel-enable pulse
//   video_on  : visible-area flag
//   pix_x/y   : current pixel coordinates
//   btn_up/down : synchronised paddle buttons (levels)
//   graph_rgb : colour code back to the top level
//   hit/miss  : one-clk event pulses
// master = the driving side (sync stage + buttons), slave = the graphics block.
interface pong_anim_graph_if;
  logic       tick_25m;
  logic       video_on;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic       btn_up;
  logic       btn_down;
  logic [3:0] graph_rgb;
  logic       hit;
  logic       miss;

  modport master (
    output tick_25m, video_on, pix_x, pix_y, btn_up, btn_down,
    input  graph_rgb, hit, miss
  );

  modport slave (
    input  tick_25m, video_on, pix_x, pix_y, btn_up, btn_down,
    output graph_rgb, hit, miss
  );
endinterface

// File: rtl/pong_object_mux.sv
// Combinational object renderer: decides which object covers the current
// pixel and returns its colour code.
//   video_on, pix_x, pix_y : scan position
//   pad_y                  : paddle top row
//   ball_x, ball_y         : ball top-left corner
//   graph_rgb              : colour (ball > paddle > wall > background)
module pong_object_mux
  import pong_pkg::*;
#(
  parameter int unsigned WALL_X_L  = 32,
  parameter int unsigned PAD_X_L   = 600,
  parameter int unsigned PAD_H     = 72,
  parameter int unsigned BALL_SIZE = 8
) (
  input  logic       video_on,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  input  logic [9:0] pad_y,
  input  logic [9:0] ball_x,
  input  logic [9:0] ball_y,
  output logic [3:0] graph_rgb
);

  localparam logic [9:0] WALL_L   = 10'(WALL_X_L);
  localparam logic [9:0] WALL_R   = 10'(WALL_X_L + 3);
  localparam logic [9:0] PAD_L    = 10'(PAD_X_L);
  localparam logic [9:0] PAD_R    = 10'(PAD_X_L + 3);
  localparam logic [9:0] PAD_EXT  = 10'(PAD_H - 1);
  localparam logic [9:0] BALL_EXT = 10'(BALL_SIZE - 1);

  logic wall_on, pad_on, ball_on;

  assign wall_on = in_range(pix_x, WALL_L, WALL_R);
  assign pad_on  = in_range(pix_x, PAD_L, PAD_R) &&
                   in_range(pix_y, pad_y, pad_y + PAD_EXT);
  assign ball_on = in_range(pix_x, ball_x, ball_x + BALL_EXT) &&
                   in_range(pix_y, ball_y, ball_y + BALL_EXT);

  always_comb begin
    graph_rgb = CLR_BLACK;
    if (video_on) begin
      if (ball_on)      graph_rgb = CLR_BALL;
      else if (pad_on)  graph_rgb = CLR_PADDLE;
      else if (wall_on) graph_rgb = CLR_WALL;
    end
  end

endmodule

// File: rtl/pong_anim_graph.sv
// Animated Pong graphics: paddle, ball and serve/play/miss FSM, all updated
// once per frame on a refresh tick taken from the pixel scan, plus the
// combinational renderer.
//   clk   : system clock
//   reset : synchronous, active-high
//   gif   : pong_anim_graph_if.slave (scan inputs, buttons, colour, hit/miss)
module pong_anim_graph
  import pong_pkg::*;
#(
  parameter int unsigned WALL_X_L     = 32,
  parameter int unsigned PAD_X_L      = 600,
  parameter int unsigned PAD_H        = 72,
  parameter int unsigned PAD_V        = 4,
  parameter int unsigned BALL_SIZE    = 8,
  parameter int unsigned BALL_V       = 2,
  parameter int unsigned SERVE_FRAMES = 60
) (
  input  logic clk,
  input  logic reset,
  pong_anim_graph_if.slave gif
);

  localparam logic [9:0] PAD_MAX    = 10'(V_ACTIVE - PAD_H);
  localparam logic [9:0] PAD_STEP   = 10'(PAD_V);
  localparam logic [9:0] PAD_Y0     = 10'((V_ACTIVE - PAD_H) / 2);
  localparam logic [9:0] PAD_EXT    = 10'(PAD_H - 1);
  localparam logic [9:0] PAD_L      = 10'(PAD_X_L);
  localparam logic [9:0] PAD_R      = 10'(PAD_X_L + 3);
  localparam logic [9:0] WALL_R     = 10'(WALL_X_L + 3);
  localparam logic [9:0] BALL_EXT   = 10'(BALL_SIZE - 1);
  localparam logic [9:0] BALL_X0    = 10'(H_ACTIVE / 2 - BALL_SIZE / 2);
  localparam logic [9:0] BALL_Y0    = 10'(V_ACTIVE / 2 - BALL_SIZE / 2);
  localparam logic [9:0] BOT_LIMIT  = 10'(V_ACTIVE - 2);
  localparam logic [9:0] MISS_LIMIT = 10'(H_ACTIVE - 1);
  localparam logic [9:0] POS_V      = 10'(BALL_V);
  localparam logic [9:0] NEG_V      = ~POS_V + 10'd1;
  localparam logic [5:0] SERVE_LAST = 6'(SERVE_FRAMES - 1);

  logic [1:0] state_reg, state_next;
  logic [5:0] serve_cnt_reg, serve_cnt_next;
  logic [9:0] pad_y_reg, pad_y_next;
  logic [9:0] ball_x_reg, ball_x_next;
  logic [9:0] ball_y_reg, ball_y_next;
  logic [9:0] vx_reg, vx_next;
  logic [9:0] vy_reg, vy_next;
  logic       hit_reg, hit_next;
  logic       miss_reg, miss_next;

  logic       frame_tick;
  logic [9:0] ball_r, ball_b;
  logic       moving_right, pad_hit;

  // Fires once per frame, on the first pixel of a vertical-blank line.
  assign frame_tick = gif.tick_25m && (gif.pix_x == 10'd0) &&
                      (gif.pix_y == 10'(TICK_LINE));

  assign ball_r       = ball_x_reg + BALL_EXT;
  assign ball_b       = ball_y_reg + BALL_EXT;
  assign moving_right = !vx_reg[9] && (vx_reg != 10'd0);
  assign pad_hit      = in_range(ball_r, PAD_L, PAD_R) && moving_right &&
                        (ball_b >= pad_y_reg) && (ball_y_reg <= pad_y_reg + PAD_EXT);

  always_comb begin
    state_next     = state_reg;
    serve_cnt_next = serve_cnt_reg;
    pad_y_next     = pad_y_reg;
    ball_x_next    = ball_x_reg;
    ball_y_next    = ball_y_reg;
    vx_next        = vx_reg;
    vy_next        = vy_reg;
    hit_next       = 1'b0;
    miss_next      = 1'b0;

    // Paddle moves in every state; the compares saturate exactly at 0 / PAD_MAX.
    if (gif.btn_up && !gif.btn_down)
      pad_y_next = (pad_y_reg <= PAD_STEP) ? 10'd0 : pad_y_reg - PAD_STEP;
    else if (gif.btn_down && !gif.btn_up)
      pad_y_next = (pad_y_reg >= PAD_MAX - PAD_STEP) ? PAD_MAX : pad_y_reg + PAD_STEP;

    case (state_reg)
      ST_SERVE: begin
        ball_x_next = BALL_X0;
        ball_y_next = BALL_Y0;
        if (serve_cnt_reg == SERVE_LAST) begin
          state_next     = ST_PLAY;
          serve_cnt_next = 6'd0;
        end else begin
          serve_cnt_next = serve_cnt_reg + 6'd1;
        end
      end
      ST_PLAY: begin
        if (ball_y_reg <= 10'd1)    vy_next = POS_V;
        if (ball_b >= BOT_LIMIT)    vy_next = NEG_V;
        if (ball_x_reg <= WALL_R)   vx_next = POS_V;
        if (pad_hit) begin
          vx_next  = NEG_V;
          hit_next = 1'b1;
        end else if (ball_r >= MISS_LIMIT) begin
          state_next = ST_MISS;
          miss_next  = 1'b1;
        end
        // Moves use the post-collision velocities; a missed ball stays put.
        if (!miss_next) begin
          ball_x_next = ball_x_reg + vx_next;
          ball_y_next = ball_y_reg + vy_next;
        end
      end
      default: begin
        state_next     = ST_SERVE;
        serve_cnt_next = 6'd0;
        ball_x_next    = BALL_X0;
        ball_y_next    = BALL_Y0;
        vx_next        = POS_V;
        vy_next        = POS_V;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_SERVE;
      serve_cnt_reg <= 6'd0;
      pad_y_reg     <= PAD_Y0;
      ball_x_reg    <= BALL_X0;
      ball_y_reg    <= BALL_Y0;
      vx_reg        <= POS_V;
      vy_reg        <= POS_V;
      hit_reg       <= 1'b0;
      miss_reg      <= 1'b0;
    end else begin
      hit_reg  <= frame_tick && hit_next;
      miss_reg <= frame_tick && miss_next;
      if (frame_tick) begin
        state_reg     <= state_next;
        serve_cnt_reg <= serve_cnt_next;
        pad_y_reg     <= pad_y_next;
        ball_x_reg    <= ball_x_next;
        ball_y_reg    <= ball_y_next;
        vx_reg        <= vx_next;
        vy_reg        <= vy_next;
      end
    end
  end

  assign gif.hit  = hit_reg;
  assign gif.miss = miss_reg;

  pong_object_mux #(
    .WALL_X_L (WALL_X_L),
    .PAD_X_L  (PAD_X_L),
    .PAD_H    (PAD_H),
    .BALL_SIZE(BALL_SIZE)
  ) u_object_mux (
    .video_on (gif.video_on),
    .pix_x    (gif.pix_x),
    .pix_y    (gif.pix_y),
    .pad_y    (pad_y_reg),
    .ball_x   (ball_x_reg),
    .ball_y   (ball_y_reg),
    .graph_rgb(gif.graph_rgb)
  );

endmodule

// File: tb/tb_pong_anim_graph.sv
// Directed bench for pong_anim_graph: reset state, serve timing, paddle
// clamping, paddle hit, wall/top bounces, miss sequence and pixel colours.
module tb_pong_anim_graph;
  import pong_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  pong_anim_graph_if gif ();

  pong_anim_graph dut (
    .clk  (clk),
    .reset(reset),
    .gif  (gif)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // One refresh tick: a single clk with tick_25m high at (0,481).
  task automatic tick();
    @(negedge clk);
    gif.tick_25m = 1'b1;
    gif.pix_x    = 10'd0;
    gif.pix_y    = 10'd481;
    @(posedge clk);
    #1;
    gif.tick_25m = 1'b0;
    gif.pix_y    = 10'd0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pix(input string tag, input int x, input int y, input logic von,
                     input logic [3:0] exp);
    gif.pix_x    = 10'(x);
    gif.pix_y    = 10'(y);
    gif.video_on = von;
    #1;
    chk(tag, {28'd0, gif.graph_rgb}, {28'd0, exp});
  endtask

  initial begin
    reset        = 1'b1;
    gif.tick_25m = 1'b0;
    gif.video_on = 1'b0;
    gif.pix_x    = 10'd0;
    gif.pix_y    = 10'd0;
    gif.btn_up   = 1'b0;
    gif.btn_down = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    chk("rst_state", {30'd0, dut.state_reg}, {30'd0, ST_SERVE});
    chk("rst_cnt", {26'd0, dut.serve_cnt_reg}, 32'd0);
    chk("rst_pad", {22'd0, dut.pad_y_reg}, 32'd204);
    chk("rst_bx", {22'd0, dut.ball_x_reg}, 32'd316);
    chk("rst_by", {22'd0, dut.ball_y_reg}, 32'd236);
    chk("rst_vx", {22'd0, dut.vx_reg}, 32'd2);
    chk("rst_vy", {22'd0, dut.vy_reg}, 32'd2);
    chk("rst_hit", {31'd0, gif.hit}, 32'd0);
    chk("rst_miss", {31'd0, gif.miss}, 32'd0);

    // Pixel colours at reset positions
    for (int y = 232; y < 248; y++)
      for (int x = 312; x < 328; x++)
        pix("ball_win", x, y, 1'b1,
            (x >= 316 && x <= 323 && y >= 236 && y <= 243) ? 4'hF : 4'h0);
    pix("ball_voff", 320, 240, 1'b0, 4'h0);
    pix("wall_l", 32, 100, 1'b1, 4'hC);
    pix("wall_r", 35, 400, 1'b1, 4'hC);
    pix("wall_out_l", 31, 100, 1'b1, 4'h0);
    pix("wall_out_r", 36, 100, 1'b1, 4'h0);
    pix("wall_voff", 33, 100, 1'b0, 4'h0);
    pix("pad_tl", 600, 204, 1'b1, 4'hA);
    pix("pad_br", 603, 275, 1'b1, 4'hA);
    pix("pad_above", 600, 203, 1'b1, 4'h0);
    pix("pad_below", 601, 276, 1'b1, 4'h0);
    pix("pad_left", 599, 250, 1'b1, 4'h0);
    pix("pad_right", 604, 250, 1'b1, 4'h0);
    pix("pad_voff", 601, 250, 1'b0, 4'h0);
    gif.video_on = 1'b0;
    gif.pix_x    = 10'd0;
    gif.pix_y    = 10'd0;

    // Serve timing
    ticks(59);
    chk("serve59_state", {30'd0, dut.state_reg}, {30'd0, ST_SERVE});
    chk("serve59_cnt", {26'd0, dut.serve_cnt_reg}, 32'd59);
    tick();
    chk("serve60_state", {30'd0, dut.state_reg}, {30'd0, ST_PLAY});
    chk("serve60_cnt", {26'd0, dut.serve_cnt_reg}, 32'd0);
    chk("serve60_bx", {22'd0, dut.ball_x_reg}, 32'd316);
    chk("serve60_by", {22'd0, dut.ball_y_reg}, 32'd236);
    tick();
    chk("play1_bx", {22'd0, dut.ball_x_reg}, 32'd318);
    chk("play1_by", {22'd0, dut.ball_y_reg}, 32'd238);

    // Paddle up with clamp at 0
    do_reset();
    gif.btn_up = 1'b1;
    tick();
    chk("up1_pad", {22'd0, dut.pad_y_reg}, 32'd200);
    ticks(50);
    chk("up51_pad", {22'd0, dut.pad_y_reg}, 32'd0);
    ticks(9);
    chk("up60_pad", {22'd0, dut.pad_y_reg}, 32'd0);
    gif.btn_down = 1'b1;
    tick();
    chk("both_at0_pad", {22'd0, dut.pad_y_reg}, 32'd0);
    gif.btn_up = 1'b0;
    tick();
    chk("down1_pad", {22'd0, dut.pad_y_reg}, 32'd4);
    gif.btn_up = 1'b1;
    tick();
    chk("both_at4_pad", {22'd0, dut.pad_y_reg}, 32'd4);
    gif.btn_up = 1'b0;
    ticks(101);
    chk("down_max_pad", {22'd0, dut.pad_y_reg}, 32'd408);
    tick();
    chk("down_sat_pad", {22'd0, dut.pad_y_reg}, 32'd408);
    gif.btn_down = 1'b0;

    // Paddle hit, then top and left-wall bounces
    do_reset();
    gif.btn_down = 1'b1;
    ticks(60);
    gif.btn_down = 1'b0;
    chk("hit_pad", {22'd0, dut.pad_y_reg}, 32'd408);
    chk("hit_state", {30'd0, dut.state_reg}, {30'd0, ST_PLAY});
    ticks(118);
    chk("bot_pre_y", {22'd0, dut.ball_y_reg}, 32'd472);
    chk("bot_pre_vy", {22'd0, dut.vy_reg}, 32'd2);
    tick();
    chk("bot_vy", {22'd0, dut.vy_reg}, 32'h3FE);
    chk("bot_y", {22'd0, dut.ball_y_reg}, 32'd470);
    ticks(20);
    chk("hit_pre_x", {22'd0, dut.ball_x_reg}, 32'd594);
    chk("hit_pre_y", {22'd0, dut.ball_y_reg}, 32'd430);
    chk("hit_pre_pulse", {31'd0, gif.hit}, 32'd0);
    tick();
    chk("hit_pulse", {31'd0, gif.hit}, 32'd1);
    chk("hit_vx", {22'd0, dut.vx_reg}, 32'h3FE);
    chk("hit_x", {22'd0, dut.ball_x_reg}, 32'd592);
    chk("hit_y", {22'd0, dut.ball_y_reg}, 32'd428);
    @(posedge clk);
    #1;
    chk("hit_pulse_end", {31'd0, gif.hit}, 32'd0);
    tick();
    chk("after_hit_x", {22'd0, dut.ball_x_reg}, 32'd590);
    ticks(213);
    chk("top_pre_y", {22'd0, dut.ball_y_reg}, 32'd0);
    chk("top_pre_vy", {22'd0, dut.vy_reg}, 32'h3FE);
    tick();
    chk("top_vy", {22'd0, dut.vy_reg}, 32'd2);
    chk("top_y", {22'd0, dut.ball_y_reg}, 32'd2);
    chk("top_x", {22'd0, dut.ball_x_reg}, 32'd162);
    ticks(64);
    chk("wall_pre_x", {22'd0, dut.ball_x_reg}, 32'd34);
    chk("wall_pre_vx", {22'd0, dut.vx_reg}, 32'h3FE);
    tick();
    chk("wall_vx", {22'd0, dut.vx_reg}, 32'd2);
    chk("wall_x", {22'd0, dut.ball_x_reg}, 32'd36);
    chk("wall_y", {22'd0, dut.ball_y_reg}, 32'd132);

    // Reset mid-play, without a refresh tick
    do_reset();
    chk("midrst_state", {30'd0, dut.state_reg}, {30'd0, ST_SERVE});
    chk("midrst_bx", {22'd0, dut.ball_x_reg}, 32'd316);
    chk("midrst_pad", {22'd0, dut.pad_y_reg}, 32'd204);
    chk("midrst_vx", {22'd0, dut.vx_reg}, 32'd2);

    // Miss sequence with paddle left at 204
    ticks(60);
    ticks(158);
    chk("miss_pre_x", {22'd0, dut.ball_x_reg}, 32'd632);
    chk("miss_pre_y", {22'd0, dut.ball_y_reg}, 32'd392);
    chk("miss_pre_state", {30'd0, dut.state_reg}, {30'd0, ST_PLAY});
    tick();
    chk("miss_pulse", {31'd0, gif.miss}, 32'd1);
    chk("miss_nohit", {31'd0, gif.hit}, 32'd0);
    chk("miss_state", {30'd0, dut.state_reg}, {30'd0, ST_MISS});
    chk("miss_x_held", {22'd0, dut.ball_x_reg}, 32'd632);
    @(posedge clk);
    #1;
    chk("miss_pulse_end", {31'd0, gif.miss}, 32'd0);
    tick();
    chk("reserve_state", {30'd0, dut.state_reg}, {30'd0, ST_SERVE});
    chk("reserve_bx", {22'd0, dut.ball_x_reg}, 32'd316);
    chk("reserve_by", {22'd0, dut.ball_y_reg}, 32'd236);
    chk("reserve_vx", {22'd0, dut.vx_reg}, 32'd2);
    chk("reserve_vy", {22'd0, dut.vy_reg}, 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
